// File: rtl/exe_mem_stage.sv
// Execute stage of the 5-stage pipeline: operand-B select, ALU, and the EXE/MEM register.
// er is exported combinationally for forwarding; stall and flush control the EXE/MEM register.
module exe_mem_stage (
   input  logic        clk,
   input  logic        clrn,
   input  logic        ewreg,
   input  logic        em2reg,
   input  logic        ewmem,
   input  logic [3:0]  ealuc,
   input  logic        ealuimm,
   input  logic [4:0]  edestReg,
   input  logic [31:0] eqa,
   input  logic [31:0] eqb,
   input  logic [31:0] eimm32,
   input  logic        stall,
   input  logic        flush,
   output logic [31:0] er,
   output logic        mwreg,
   output logic        mm2reg,
   output logic        mwmem,
   output logic [4:0]  mdestReg,
   output logic [31:0] mr,
   output logic [31:0] mqb
);

   // ALU operation encodings
   localparam logic [2:0] OP_ADD   = 3'b000;
   localparam logic [2:0] OP_AND   = 3'b001;
   localparam logic [2:0] OP_XOR   = 3'b010;
   localparam logic [2:0] OP_SLL_Z = 3'b011;
   localparam logic [2:0] OP_SUB   = 3'b100;
   localparam logic [2:0] OP_OR    = 3'b101;
   localparam logic [2:0] OP_LUI   = 3'b110;
   localparam logic [2:0] OP_SHR   = 3'b111;

   // Only a[4:0] feeds the barrel shifter, so a shift of 32 behaves as 0.
   function automatic logic [31:0] alu_eval(
      input logic [3:0]  op,
      input logic [31:0] a,
      input logic [31:0] b
   );
      logic [4:0]  sh;
      logic [31:0] res;
      sh  = a[4:0];
      res = 32'h0000_0000;
      unique case (op[2:0])
         OP_ADD:   res = a + b;
         OP_SUB:   res = a - b;
         OP_AND:   res = a & b;
         OP_OR:    res = a | b;
         OP_XOR:   res = a ^ b;
         OP_LUI:   res = {b[15:0], 16'h0000};
         OP_SLL_Z: res = op[3] ? 32'h0000_0000 : (b << sh);
         OP_SHR:   res = op[3] ? 32'($signed(b) >>> sh) : (b >> sh);
         default:  res = 32'h0000_0000;
      endcase
      return res;
   endfunction

   logic [31:0] alu_b;

   logic        mwreg_d,    mwreg_q;
   logic        mm2reg_d,   mm2reg_q;
   logic        mwmem_d,    mwmem_q;
   logic [4:0]  mdestreg_d, mdestreg_q;
   logic [31:0] mr_d,       mr_q;
   logic [31:0] mqb_d,      mqb_q;

   always_comb begin
      alu_b = ealuimm ? eimm32 : eqb;
      er    = alu_eval(ealuc, eqa, alu_b);
   end

   // Flush outranks stall so a bubble is inserted even while the pipe is held.
   always_comb begin
      mwreg_d    = mwreg_q;
      mm2reg_d   = mm2reg_q;
      mwmem_d    = mwmem_q;
      mdestreg_d = mdestreg_q;
      mr_d       = mr_q;
      mqb_d      = mqb_q;
      if (flush) begin
         mwreg_d    = 1'b0;
         mm2reg_d   = 1'b0;
         mwmem_d    = 1'b0;
         mdestreg_d = 5'd0;
         mr_d       = 32'h0000_0000;
         mqb_d      = 32'h0000_0000;
      end else if (!stall) begin
         mwreg_d    = ewreg;
         mm2reg_d   = em2reg;
         mwmem_d    = ewmem;
         mdestreg_d = edestReg;
         mr_d       = er;
         mqb_d      = eqb;
      end
   end

   // EXE/MEM pipeline register
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         mwreg_q    <= 1'b0;
         mm2reg_q   <= 1'b0;
         mwmem_q    <= 1'b0;
         mdestreg_q <= 5'd0;
         mr_q       <= 32'h0000_0000;
         mqb_q      <= 32'h0000_0000;
      end else begin
         mwreg_q    <= mwreg_d;
         mm2reg_q   <= mm2reg_d;
         mwmem_q    <= mwmem_d;
         mdestreg_q <= mdestreg_d;
         mr_q       <= mr_d;
         mqb_q      <= mqb_d;
      end
   end

   assign mwreg    = mwreg_q;
   assign mm2reg   = mm2reg_q;
   assign mwmem    = mwmem_q;
   assign mdestReg = mdestreg_q;
   assign mr       = mr_q;
   assign mqb      = mqb_q;

endmodule

// File: tb/tb_exe_mem_stage.sv
// Self-checking bench for exe_mem_stage: directed test-plan cases plus randomized
// traffic with stall/flush, compared against a behavioural model of the stage.
module tb_exe_mem_stage;

   logic        clk = 1'b0;
   logic        clrn;
   logic        ewreg, em2reg, ewmem, ealuimm, stall, flush;
   logic [3:0]  ealuc;
   logic [4:0]  edestReg;
   logic [31:0] eqa, eqb, eimm32;
   logic [31:0] er, mr, mqb;
   logic        mwreg, mm2reg, mwmem;
   logic [4:0]  mdestReg;

   int n_checks = 0;
   int n_errors = 0;

   // model of the EXE/MEM register contents
   logic        x_wreg, x_m2reg, x_wmem;
   logic [4:0]  x_dest;
   logic [31:0] x_r, x_qb;

   always #5 clk = ~clk;

   exe_mem_stage dut (
      .clk(clk), .clrn(clrn), .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
      .ealuc(ealuc), .ealuimm(ealuimm), .edestReg(edestReg), .eqa(eqa), .eqb(eqb),
      .eimm32(eimm32), .stall(stall), .flush(flush), .er(er), .mwreg(mwreg),
      .mm2reg(mm2reg), .mwmem(mwmem), .mdestReg(mdestReg), .mr(mr), .mqb(mqb)
   );

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference ALU written from the operation table.
   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      int unsigned sh;
      logic [31:0] fill;
      sh = a % 32;
      case (op)
         4'h0, 4'h8: return a + b;
         4'h4, 4'hC: return a + ~b + 32'd1;
         4'h1, 4'h9: return a & b;
         4'h5, 4'hD: return a | b;
         4'h2, 4'hA: return a ^ b;
         4'h6, 4'hE: return b * 32'd65536;
         4'h3:       return b << sh;
         4'h7:       return b >> sh;
         4'hF: begin
            fill = b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
            return (b >> sh) | fill;
         end
         default:    return 32'h0;
      endcase
   endfunction

   task automatic set_in(input logic [3:0] op, input logic imm_sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm);
      ealuc = op; ealuimm = imm_sel; eqa = a; eqb = b; eimm32 = imm;
   endtask

   task automatic check_m(input string tag);
      chk_eq({tag, "_mwreg"},  32'(mwreg),    32'(x_wreg));
      chk_eq({tag, "_mm2reg"}, 32'(mm2reg),   32'(x_m2reg));
      chk_eq({tag, "_mwmem"},  32'(mwmem),    32'(x_wmem));
      chk_eq({tag, "_mdest"},  32'(mdestReg), 32'(x_dest));
      chk_eq({tag, "_mr"},     mr,            x_r);
      chk_eq({tag, "_mqb"},    mqb,           x_qb);
   endtask

   // Inputs already applied; check er, clock one edge, check registered outputs.
   task automatic step(input string tag);
      logic [31:0] exp_er;
      #1;
      exp_er = ref_alu(ealuc, eqa, ealuimm ? eimm32 : eqb);
      chk_eq({tag, "_er"}, er, exp_er);
      @(posedge clk);
      if (flush) begin
         x_wreg = 0; x_m2reg = 0; x_wmem = 0; x_dest = 0; x_r = 0; x_qb = 0;
      end else if (!stall) begin
         x_wreg = ewreg; x_m2reg = em2reg; x_wmem = ewmem; x_dest = edestReg;
         x_r = exp_er; x_qb = eqb;
      end
      #1;
      check_m(tag);
   endtask

   initial begin
      logic [3:0]  ops [5];
      logic [31:0] exps [5];
      ops  = '{4'h0, 4'h4, 4'h1, 4'h5, 4'h2};
      exps = '{32'hFFFF_FFF5, 32'h0000_0015, 32'h0, 32'hFFFF_FFF5, 32'hFFFF_FFF5};

      clrn = 0; stall = 0; flush = 0;
      ewreg = 0; em2reg = 0; ewmem = 0; edestReg = 0;
      set_in(4'h0, 0, 0, 0, 0);
      x_wreg = 0; x_m2reg = 0; x_wmem = 0; x_dest = 0; x_r = 0; x_qb = 0;
      #1;
      check_m("rst");
      @(posedge clk); #1;
      check_m("rst_hold");
      @(negedge clk); clrn = 1;
      @(posedge clk); #1;

      // ALU sweep with register operand
      ewreg = 1; edestReg = 5'd3;
      for (int i = 0; i < 5; i++) begin
         set_in(ops[i], 0, 32'h0000_0005, 32'hFFFF_FFF0, 32'h0);
         #1 chk_eq("sweep_er_const", er, exps[i]);
         step("sweep");
         chk_eq("sweep_mr_const", mr, exps[i]);
      end

      // lui and shifts through the immediate
      set_in(4'h6, 1, 32'h0, 32'h0, 32'h0000_ABCD);
      #1 chk_eq("lui", er, 32'hABCD_0000);
      step("lui");
      set_in(4'h3, 1, 32'd4, 32'h0, 32'h8000_0000); #1 chk_eq("sll", er, 32'h0);
      step("sll");
      set_in(4'h7, 1, 32'd4, 32'h0, 32'h8000_0000); #1 chk_eq("srl", er, 32'h0800_0000);
      step("srl");
      set_in(4'hF, 1, 32'd4, 32'h0, 32'h8000_0000); #1 chk_eq("sra", er, 32'hF800_0000);
      step("sra");
      set_in(4'hF, 1, 32'h24, 32'h0, 32'h8000_0000); #1 chk_eq("sra_hi", er, 32'hF800_0000);
      step("sra_hi");
      set_in(4'h3, 1, 32'd32, 32'h0, 32'h0000_0001); #1 chk_eq("sll32", er, 32'h1);
      step("sll32");
      set_in(4'hB, 0, 32'h1234, 32'h5678, 32'h0); #1 chk_eq("zero_op", er, 32'h0);
      step("zero_op");

      // wraparound
      set_in(4'h0, 0, 32'h7FFF_FFFF, 32'h1, 32'h0); #1 chk_eq("add_wrap", er, 32'h8000_0000);
      step("add_wrap");
      set_in(4'h4, 0, 32'h0, 32'h1, 32'h0); #1 chk_eq("sub_wrap", er, 32'hFFFF_FFFF);
      step("sub_wrap");

      // store path: mqb carries eqb, not the immediate
      ewreg = 0; ewmem = 1; edestReg = 5'd0;
      set_in(4'h0, 1, 32'h100, 32'hDEAD_BEEF, 32'd8);
      step("store");
      chk_eq("store_mr", mr, 32'h108);
      chk_eq("store_mqb", mqb, 32'hDEAD_BEEF);
      chk_eq("store_mwmem", 32'(mwmem), 32'd1);

      // stall for 3 cycles with changing inputs
      ewmem = 0; ewreg = 1; em2reg = 1; edestReg = 5'd9;
      set_in(4'h0, 0, 32'h11, 32'h22, 32'h0);
      step("pre_stall");
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         edestReg = 5'(i + 20);
         set_in(4'h5, 0, 32'(i * 7), 32'hF0F0_0000, 32'h0);
         step("stall");
         chk_eq("stall_mr_frozen", mr, 32'h33);
      end
      flush = 1;
      step("stall_flush");
      chk_eq("flush_mwreg", 32'(mwreg), 32'd0);
      chk_eq("flush_mr", mr, 32'h0);
      stall = 0; flush = 0;
      set_in(4'h2, 0, 32'hAAAA_0000, 32'h0000_5555, 32'h0);
      step("resume");
      chk_eq("resume_mr", mr, 32'hAAAA_5555);

      // asynchronous reset mid-cycle
      set_in(4'h0, 0, 32'h1000, 32'h0234, 32'h0);
      step("pre_rst");
      chk_eq("pre_rst_mr", mr, 32'h1234);
      #2 clrn = 0;
      x_wreg = 0; x_m2reg = 0; x_wmem = 0; x_dest = 0; x_r = 0; x_qb = 0;
      #1 check_m("async_rst");
      @(posedge clk); #1 check_m("async_rst_hold");
      @(negedge clk); clrn = 1;
      #1 check_m("rst_release");
      step("post_rst");

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         ewreg = 1'($urandom); em2reg = 1'($urandom); ewmem = 1'($urandom);
         edestReg = 5'($urandom);
         set_in(4'($urandom), 1'($urandom),
                ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                $urandom, $urandom);
         stall = ($urandom_range(0, 4) == 0);
         flush = ($urandom_range(0, 6) == 0);
         step("rand");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/exe_mem_stage.md
# exe_mem_stage

Execute stage of the 5-stage pipelined CPU together with its EXE/MEM pipeline register. Consumes the ID/EXE register outputs (control bits, destination register, operands, sign-extended immediate), selects the second ALU operand, evaluates the ALU, and registers the result plus memory-stage controls for the MEM stage. Also exports the combinational EXE result for forwarding and supports hold (stall) and bubble insertion (flush).

## Interface
- No parameters; data width fixed at 32, register index 5, ALU control 4.
- clk  in  1  rising-edge clock
- clrn  in  1  asynchronous active-low reset
- ewreg  in  1  EXE: write register file
- em2reg  in  1  EXE: writeback selects memory data
- ewmem  in  1  EXE: write data memory
- ealuc  in  4  EXE: ALU operation
- ealuimm  in  1  EXE: second operand is eimm32 (else eqb)
- edestReg  in  5  EXE: destination register
- eqa  in  32  EXE: operand A
- eqb  in  32  EXE: operand B / store data
- eimm32  in  32  EXE: extended immediate
- stall  in  1  hold EXE/MEM register contents
- flush  in  1  load a bubble into EXE/MEM
- er  out  32  combinational ALU result (forwarding)
- mwreg, mm2reg, mwmem  out  1 each  registered controls
- mdestReg  out  5  registered destination
- mr  out  32  registered ALU result
- mqb  out  32  registered store data (eqb, never the immediate)

## Operation
- b = ealuimm ? eimm32 : eqb; a = eqa.
- ALU (er), by ealuc:
  - x000 add: a+b, 32-bit wrap, no overflow flag
  - x100 sub: a-b, 32-bit wrap
  - x001 and; x101 or; x010 xor
  - x110 lui: {b[15:0], 16'h0000}
  - 0011 sll: b << a[4:0]; 0111 srl: b >> a[4:0] logical; 1111 sra: arithmetic on b
  - 1011: er = 0
- er is purely combinational from current inputs; valid every cycle.
- Register update each rising clk edge, priority: clrn low > flush > stall > normal.
  - flush: mwreg=mm2reg=mwmem=0; mdestReg, mr, mqb = 0.
  - stall (flush low): all EXE/MEM outputs keep previous values.
  - normal: mwreg<=ewreg, mm2reg<=em2reg, mwmem<=ewmem, mdestReg<=edestReg, mr<=er, mqb<=eqb.
- No internal state besides the EXE/MEM register.

## Timing
- Latency: 1 cycle from EXE inputs to m* outputs; er: 0 cycles.
- clrn low: all m* outputs to 0 immediately (asynchronous), held while low; first capture on first rising edge after clrn deasserts.
- Reset values: mwreg=0, mm2reg=0, mwmem=0, mdestReg=0, mr=0, mqb=0.
- stall and flush together: flush wins (bubble).
- Stall held N cycles: outputs constant for N edges; capture resumes on first edge with stall low.
- Shift amount uses only a[4:0]; a[31:5] ignored (shift by 32 = shift by 0).

## Test plan
- Reset: clrn=0 mid-run with mr=32'h1234 -> all m* read 0 before next edge; stay 0 until clrn=1 and an edge.
- ALU sweep: eqa=32'h0000_0005, eqb=32'hFFFF_FFF0, ealuimm=0 -> add 32'hFFFF_FFF5, sub 32'h0000_0015, and 0, or 32'hFFFF_FFF5, xor 32'hFFFF_FFF5; mr equals er one edge later.
- Immediate/lui/shifts: ealuimm=1, eimm32=32'h0000_ABCD, lui -> 32'hABCD_0000; eimm32=32'h8000_0000, eqa=4: sll 0, srl 32'h0800_0000, sra 32'hF800_0000; eqa=32'h24 shifts by 4.
- Overflow wrap: add 32'h7FFF_FFFF+1 -> 32'h8000_0000; sub 0-1 -> 32'hFFFF_FFFF; no extra output.
- Store path: ewmem=1, ealuimm=1, eqa=32'h100, eimm32=8, eqb=32'hDEAD_BEEF -> mr=32'h108, mqb=32'hDEAD_BEEF, mwmem=1, mwreg=0.
- Hazard controls: stall 3 cycles while inputs change -> m* frozen; stall+flush same edge -> mwreg=mm2reg=mwmem=0, mdestReg=0, mr=0; next normal edge captures current inputs.
